// File: rtl/serial_negate_word.sv
// Digit-serial two's-complement negator with word framing and most-negative overflow flag.
// Optional sticky overflow with clear input when OVF_STICKY_EN is defined.
module serial_negate_word #(
  parameter int DIGIT     = 1,
  parameter int WORD_BITS = 8
) (
  input  logic             t_clk,
  input  logic             r,
  input  logic [DIGIT-1:0] i,
  input  logic             i_valid,
  input  logic             neg,
  output logic [DIGIT-1:0] y,
  output logic             y_valid,
  output logic             y_first,
  output logic             y_last,
  output logic             ovf
`ifdef OVF_STICKY_EN
  ,
  input  logic             ovf_clr,
  output logic             ovf_sticky
`endif
);

  localparam int NDIG = WORD_BITS / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_POS = CW'(NDIG - 1);

  logic [CW-1:0]    pos_reg, pos_next;
  logic             s_reg, s_next;
  logic             m_reg;
  logic [DIGIT-1:0] y_reg, y_next;
  logic             y_valid_reg, y_first_reg, y_last_reg, ovf_reg, ovf_next;

  logic             first_digit, last_digit, em, es;
  logic [DIGIT-1:0] t;

  assign first_digit = (pos_reg == '0);
  assign last_digit  = (pos_reg == LAST_POS);
  // The first digit of a word ignores any stale state left by an earlier word.
  assign em = first_digit ? neg  : m_reg;
  assign es = first_digit ? 1'b0 : s_reg;

  // t[b] is high once a 1 has appeared below bit b anywhere in the word so far.
  genvar gi;
  generate
    for (gi = 0; gi < DIGIT; gi++) begin : g_prefix
      localparam logic [DIGIT-1:0] BELOW = DIGIT'((64'd1 << gi) - 64'd1);
      assign t[gi] = es | (|(i & BELOW));
    end
  endgenerate

  assign y_next   = em ? (i ^ t) : i;
  assign s_next   = es | (|i);
  assign pos_next = last_digit ? '0 : pos_reg + 1'b1;
  // Only 100..0 negates to itself: top bit set with nothing set beneath it.
  assign ovf_next = em & last_digit & i[DIGIT-1] & ~t[DIGIT-1];

  always_ff @(posedge t_clk) begin
    if (r) begin
      y_reg       <= '0;
      y_valid_reg <= 1'b0;
      y_first_reg <= 1'b0;
      y_last_reg  <= 1'b0;
      ovf_reg     <= 1'b0;
      pos_reg     <= '0;
      s_reg       <= 1'b0;
      m_reg       <= 1'b0;
    end else if (i_valid) begin
      y_reg       <= y_next;
      y_valid_reg <= 1'b1;
      y_first_reg <= first_digit;
      y_last_reg  <= last_digit;
      ovf_reg     <= ovf_next;
      pos_reg     <= pos_next;
      s_reg       <= s_next;
      m_reg       <= em;
    end else begin
      y_valid_reg <= 1'b0;
      y_first_reg <= 1'b0;
      y_last_reg  <= 1'b0;
      ovf_reg     <= 1'b0;
    end
  end

  assign y       = y_reg;
  assign y_valid = y_valid_reg;
  assign y_first = y_first_reg;
  assign y_last  = y_last_reg;
  assign ovf     = ovf_reg;

`ifdef OVF_STICKY_EN
  logic ovf_sticky_reg;

  // A fresh overflow beats a simultaneous clear so no event is lost.
  always_ff @(posedge t_clk) begin
    if (r) begin
      ovf_sticky_reg <= 1'b0;
    end else if (ovf_reg) begin
      ovf_sticky_reg <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky_reg <= 1'b0;
    end
  end

  assign ovf_sticky = ovf_sticky_reg;
`endif

endmodule

// File: tb/tb_serial_negate_word.sv
// Directed bench for serial_negate_word: one DIGIT=1 and one DIGIT=4 instance, both 8-bit words.
module tb_serial_negate_word;

  logic       t_clk = 1'b0;
  logic       r;
  logic       i1, i1_valid, neg1;
  logic       y1, y1_valid, y1_first, y1_last, ovf1;
  logic [3:0] i4, y4;
  logic       i4_valid, neg4, y4_valid, y4_first, y4_last, ovf4;
`ifdef OVF_STICKY_EN
  logic       ovf_clr1, ovf_sticky1, ovf_sticky4;
  logic       ovf_clr4 = 1'b0;
`endif

  int passed = 0;
  int total  = 0;

  always #5 t_clk = ~t_clk;

  serial_negate_word #(.DIGIT(1), .WORD_BITS(8)) u1 (
    .t_clk(t_clk), .r(r), .i(i1), .i_valid(i1_valid), .neg(neg1),
    .y(y1), .y_valid(y1_valid), .y_first(y1_first), .y_last(y1_last), .ovf(ovf1)
`ifdef OVF_STICKY_EN
    , .ovf_clr(ovf_clr1), .ovf_sticky(ovf_sticky1)
`endif
  );

  serial_negate_word #(.DIGIT(4), .WORD_BITS(8)) u4 (
    .t_clk(t_clk), .r(r), .i(i4), .i_valid(i4_valid), .neg(neg4),
    .y(y4), .y_valid(y4_valid), .y_first(y4_first), .y_last(y4_last), .ovf(ovf4)
`ifdef OVF_STICKY_EN
    , .ovf_clr(ovf_clr4), .ovf_sticky(ovf_sticky4)
`endif
  );

  typedef struct {
    logic       neg;
    logic [7:0] word;
    logic [7:0] exp_word;
    logic       exp_ovf;
  } vec_t;

  vec_t v1 [8];
  vec_t v4 [4];

  task automatic step();
    @(posedge t_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Sends one 8-bit word bit-serially; neg is inverted after bit 0 to prove it is latched.
  task automatic send_word1(input string name, input logic negv, input logic [7:0] word,
                            input logic [7:0] exp_word, input logic exp_ovf,
                            input int gap_after, input int gap_len);
    logic [7:0] got, fm, lm, vm, om;
    for (int b = 0; b < 8; b++) begin
      i1 = word[b];
      i1_valid = 1'b1;
      neg1 = (b == 0) ? negv : ~negv;
      step();
      got[b] = y1; fm[b] = y1_first; lm[b] = y1_last; vm[b] = y1_valid; om[b] = ovf1;
      if (b == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          i1_valid = 1'b0;
          i1 = ~i1;
          neg1 = ~neg1;
          step();
          chk($sformatf("%s gap%0d ctl", name, g), {y1_valid, y1_first, y1_last, ovf1}, 4'b0000);
          chk($sformatf("%s gap%0d y hold", name, g), y1, got[b]);
        end
      end
    end
    $display("word1 %s neg=%0d in=%02h out=%02h ovf=%0d", name, negv, word, got, om[7]);
    chk({name, " word"}, got, exp_word);
    chk({name, " ovf"}, om, {exp_ovf, 7'b0});
    chk({name, " first"}, fm, 8'h01);
    chk({name, " last"}, lm, 8'h80);
    chk({name, " valid"}, vm, 8'hFF);
  endtask

  task automatic send_word4(input string name, input logic negv, input logic [7:0] word,
                            input logic [7:0] exp_word, input logic exp_ovf);
    logic [7:0] got;
    logic [1:0] fm, lm, om;
    for (int d = 0; d < 2; d++) begin
      i4 = word[d*4 +: 4];
      i4_valid = 1'b1;
      neg4 = (d == 0) ? negv : ~negv;
      step();
      got[d*4 +: 4] = y4; fm[d] = y4_first; lm[d] = y4_last; om[d] = ovf4;
    end
    $display("word4 %s neg=%0d in=%02h out=%02h ovf=%0d", name, negv, word, got, om[1]);
    chk({name, " word"}, got, exp_word);
    chk({name, " ovf"}, om, {exp_ovf, 1'b0});
    chk({name, " frame"}, {fm, lm}, 4'b0110);
  endtask

  initial begin
    v1[0] = '{1'b1, 8'h0C, 8'hF4, 1'b0};
    v1[1] = '{1'b1, 8'h80, 8'h80, 1'b1};
    v1[2] = '{1'b1, 8'h00, 8'h00, 1'b0};
    v1[3] = '{1'b1, 8'h01, 8'hFF, 1'b0};
    v1[4] = '{1'b0, 8'h5A, 8'h5A, 1'b0};
    v1[5] = '{1'b0, 8'h80, 8'h80, 1'b0};
    v1[6] = '{1'b1, 8'h7F, 8'h81, 1'b0};
    v1[7] = '{1'b1, 8'hFF, 8'h01, 1'b0};
    v4[0] = '{1'b1, 8'h0C, 8'hF4, 1'b0};
    v4[1] = '{1'b0, 8'h5A, 8'h5A, 1'b0};
    v4[2] = '{1'b1, 8'h80, 8'h80, 1'b1};
    v4[3] = '{1'b1, 8'h10, 8'hF0, 1'b0};

    r = 1'b1; i1 = 1'b1; i1_valid = 1'b1; neg1 = 1'b1;
    i4 = 4'hF; i4_valid = 1'b1; neg4 = 1'b1;
`ifdef OVF_STICKY_EN
    ovf_clr1 = 1'b0;
`endif
    step();
    step();
    chk("reset u1", {y1, y1_valid, y1_first, y1_last, ovf1}, 5'b0);
    chk("reset u4", {y4, y4_valid, y4_first, y4_last, ovf4}, 8'b0);
    r = 1'b0; i1_valid = 1'b0; i4_valid = 1'b0;
    step();

    // Back-to-back words on the bit-serial instance.
    for (int k = 0; k < 8; k++)
      send_word1($sformatf("v1[%0d]", k), v1[k].neg, v1[k].word, v1[k].exp_word, v1[k].exp_ovf, -1, 0);
    i1_valid = 1'b0;
    step();
    chk("idle after v1", {y1_valid, y1_first, y1_last, ovf1}, 4'b0);

    for (int k = 0; k < 4; k++)
      send_word4($sformatf("v4[%0d]", k), v4[k].neg, v4[k].word, v4[k].exp_word, v4[k].exp_ovf);
    i4_valid = 1'b0;
    step();
    chk("idle after v4", {y4_valid, y4_first, y4_last, ovf4}, 4'b0);

    // Mid-word gap of three cycles after bit 2.
    send_word1("gap 06", 1'b1, 8'h06, 8'hFA, 1'b0, 2, 3);

    // Reset mid-word, asserted together with a valid digit.
    i1 = 1'b0; i1_valid = 1'b1; neg1 = 1'b1; step();
    i1 = 1'b0; step();
    i1 = 1'b1; step();
    r = 1'b1; i1 = 1'b1; step();
    $display("reset mid-word y=%0d y_valid=%0d", y1, y1_valid);
    chk("mid reset outs", {y1, y1_valid, y1_first, y1_last, ovf1}, 5'b0);
    r = 1'b0;
    send_word1("after reset 03", 1'b1, 8'h03, 8'hFD, 1'b0, -1, 0);
    i1_valid = 1'b0;
    step();

`ifdef OVF_STICKY_EN
    chk("sticky initial", ovf_sticky1, 1'b0);
    send_word1("sticky 80", 1'b1, 8'h80, 8'h80, 1'b1, -1, 0);
    i1_valid = 1'b0;
    step();
    chk("sticky set", ovf_sticky1, 1'b1);
    send_word1("sticky 01", 1'b1, 8'h01, 8'hFF, 1'b0, -1, 0);
    i1_valid = 1'b0;
    step();
    chk("sticky held", ovf_sticky1, 1'b1);
    ovf_clr1 = 1'b1; step(); ovf_clr1 = 1'b0;
    $display("sticky after clr=%0d", ovf_sticky1);
    chk("sticky cleared", ovf_sticky1, 1'b0);
    send_word1("sticky 80b", 1'b1, 8'h80, 8'h80, 1'b1, -1, 0);
    i1_valid = 1'b0; ovf_clr1 = 1'b1;
    step();
    ovf_clr1 = 1'b0;
    chk("sticky set beats clr", ovf_sticky1, 1'b1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
